// File: rtl/health_pkg.sv
// Shared types and default watchdog limits for the health monitor datapath.
package health_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, FINISH} sched_state_t;

    localparam int SETTLE_MAX_DFLT   = 16;
    localparam int CONV_TIMEOUT_DFLT = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from last_ch+1, wrapping.
// Purely combinational; no backpressure, the caller decides when to take the pick.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last_ch,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx
);

    logic            found;
    logic [CH_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Offset N_CH lands back on last_ch, so a lone requester may win again.
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_W'((int'(last_ch) + i) % N_CH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Shares one delay_counter and one ADC between N_CH channels: settle, convert, report.
// All outputs registered; grant on the edge req is seen, done the cycle after adc_done; req is level, no abort.
module sample_scheduler
    import health_pkg::*;
#(
    parameter  int N_CH         = 4,
    parameter  int SETTLE_MAX   = SETTLE_MAX_DFLT,
    parameter  int CONV_TIMEOUT = CONV_TIMEOUT_DFLT,
    localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            dly_done,
    input  logic            adc_done,
    output logic            dly_clr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] sel,
    output logic            adc_start,
    output logic [N_CH-1:0] done,
    output logic            err,
    output logic            busy
);

    localparam int WD_MAX = (SETTLE_MAX > CONV_TIMEOUT) ? SETTLE_MAX : CONV_TIMEOUT;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    sched_state_t    state, state_nxt;
    logic [WD_W-1:0] wd, wd_nxt;
    logic [CH_W-1:0] last_ch, last_nxt, sel_nxt, arb_idx;
    logic [N_CH-1:0] grant_nxt, done_nxt, arb_grant;
    logic            dly_clr_nxt, adc_start_nxt, err_nxt, busy_nxt;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req     (req),
        .last_ch (last_ch),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wd        <= '0;
            last_ch   <= CH_W'(N_CH - 1);
            grant     <= '0;
            sel       <= '0;
            dly_clr   <= 1'b1;
            adc_start <= 1'b0;
            done      <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            wd        <= wd_nxt;
            last_ch   <= last_nxt;
            grant     <= grant_nxt;
            sel       <= sel_nxt;
            dly_clr   <= dly_clr_nxt;
            adc_start <= adc_start_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state logic computes the value each registered output takes in the coming cycle.
    always_comb begin
        state_nxt     = state;
        wd_nxt        = wd;
        last_nxt      = last_ch;
        grant_nxt     = grant;
        sel_nxt       = sel;
        dly_clr_nxt   = 1'b1;
        adc_start_nxt = 1'b0;
        done_nxt      = '0;
        err_nxt       = 1'b0;
        busy_nxt      = 1'b1;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (|req) begin
                    state_nxt   = SETTLE;
                    grant_nxt   = arb_grant;
                    sel_nxt     = arb_idx;
                    wd_nxt      = '0;
                    dly_clr_nxt = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end
            SETTLE: begin
                if (dly_done) begin
                    state_nxt     = CONVERT;
                    adc_start_nxt = 1'b1;
                    wd_nxt        = '0;
                end else if (wd == WD_W'(SETTLE_MAX - 1)) begin
                    state_nxt = FINISH;
                    done_nxt  = grant;
                    err_nxt   = 1'b1;
                end else begin
                    wd_nxt      = wd + 1'b1;
                    dly_clr_nxt = 1'b0;
                end
            end
            CONVERT: begin
                if (adc_done) begin
                    state_nxt = FINISH;
                    done_nxt  = grant;
                end else if (wd == WD_W'(CONV_TIMEOUT - 1)) begin
                    state_nxt = FINISH;
                    done_nxt  = grant;
                    err_nxt   = 1'b1;
                end else begin
                    wd_nxt = wd + 1'b1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                last_nxt  = sel;
                grant_nxt = '0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// Scenario bench for sample_scheduler: expected completions queued at request time, checked at done.
module tb_sample_scheduler;

    typedef struct packed {
        logic [3:0] ch;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       dly_done;
    logic       adc_done;
    logic       dly_clr;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       adc_start;
    logic [3:0] done;
    logic       err;
    logic       busy;

    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t sb[$];

    localparam logic [13:0] RST_VALS = 14'b1_0000_00_0_0000_0_0;

    sample_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dly_done  (dly_done),
        .adc_done  (adc_done),
        .dly_clr   (dly_clr),
        .grant     (grant),
        .sel       (sel),
        .adc_start (adc_start),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Answers the delay counter and ADC for a granted transaction and reports what was seen.
    // settle_n/conv_n = 0 means never answer.
    task automatic service(input int settle_n, input int conv_n,
                           output logic [3:0] d, output logic e,
                           output int n_low, output int n_start,
                           output int n_conv, output int n_conv_low, output bit to);
        int  k;
        bit  in_conv;
        k = 0; in_conv = 0; n_low = 0; n_start = 0; n_conv = 0; n_conv_low = 0;
        d = '0; e = 1'b0; to = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done !== 4'b0000) begin
                d = done; e = err; to = 1'b0;
                break;
            end
            if (adc_start === 1'b1) begin
                in_conv = 1'b1;
                n_start++;
            end
            if (dly_clr === 1'b0) n_low++;
            if (in_conv) begin
                n_conv++;
                if (dly_clr === 1'b0) n_conv_low++;
            end
            dly_done = 1'b0;
            adc_done = 1'b0;
            if (!in_conv) begin
                k++;
                if (settle_n != 0 && k == settle_n) dly_done = 1'b1;
            end else if (conv_n != 0 && n_conv == conv_n) begin
                adc_done = 1'b1;
            end
            tick();
        end
        dly_done = 1'b0;
        adc_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; dly_done = 1'b0; adc_done = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({dly_clr, grant, sel, adc_start, done, err, busy} !== RST_VALS) begin n_mis++; $display("FAIL reset_values: got %b expected %b", {dly_clr, grant, sel, adc_start, done, err, busy}, RST_VALS); end
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++; if ({busy, dly_clr, grant} !== 6'b0_1_0000) begin n_mis++; $display("FAIL idle_after_release: got busy=%b dly_clr=%b grant=%b expected 0 1 0000", busy, dly_clr, grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] d; logic e; int nl, ns, nc, ncl; bit to; exp_t x;
        for (int t = 0; t < 4; t++) begin
            if (t == 0) begin
                req = 4'b1111;
                for (int j = 0; j < 4; j++) sb.push_back({4'b0001 << j, 1'b0});
            end
            tick();
            n_cmp++; if (sb.size() == 0 || grant !== sb[0].ch) begin n_mis++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, grant, (sb.size() == 0) ? 4'b0000 : sb[0].ch); end
            if (t == 3) req = '0;
            service(2, 1, d, e, nl, ns, nc, ncl, to);
            n_cmp++; if (to) begin n_mis++; $display("FAIL rr_timeout[%0d]: no done within budget", t); end
            x = (sb.size() != 0) ? sb.pop_front() : '0;
            n_cmp++; if ({d, e} !== x) begin n_mis++; $display("FAIL rr_done[%0d]: got done=%b err=%b expected done=%b err=%b", t, d, e, x.ch, x.e); end
            n_cmp++; if (nc != 1) begin n_mis++; $display("FAIL rr_adc_same_cycle[%0d]: got %0d convert cycles expected 1", t, nc); end
            tick();
            n_cmp++; if ({busy, grant} !== 5'b0_0000) begin n_mis++; $display("FAIL rr_idle_gap[%0d]: got busy=%b grant=%b expected 0 0000", t, busy, grant); end
        end
    endtask

    task automatic test_single();
        logic [3:0] d; logic e; int nl, ns, nc, ncl; bit to; exp_t x;
        req = 4'b0100;
        sb.push_back({4'b0100, 1'b0});
        tick();
        n_cmp++; if ({grant, sel, busy, dly_clr} !== 8'b0100_10_1_0) begin n_mis++; $display("FAIL single_grant: got grant=%b sel=%0d busy=%b dly_clr=%b expected 0100 2 1 0", grant, sel, busy, dly_clr); end
        req = '0;
        service(8, 3, d, e, nl, ns, nc, ncl, to);
        n_cmp++; if (to) begin n_mis++; $display("FAIL single_timeout: no done within budget"); end
        n_cmp++; if (nl != 8) begin n_mis++; $display("FAIL single_dly_clr_low: got %0d cycles expected 8", nl); end
        n_cmp++; if (ns != 1) begin n_mis++; $display("FAIL single_adc_start: got %0d pulses expected 1", ns); end
        n_cmp++; if (nc != 3) begin n_mis++; $display("FAIL single_convert_len: got %0d expected 3", nc); end
        x = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++; if ({d, e} !== x) begin n_mis++; $display("FAIL single_done: got done=%b err=%b expected done=%b err=%b", d, e, x.ch, x.e); end
        tick();
        n_cmp++; if ({busy, grant, done} !== 9'b0_0000_0000) begin n_mis++; $display("FAIL single_back_idle: got busy=%b grant=%b done=%b expected all 0", busy, grant, done); end
    endtask

    task automatic test_settle_timeout();
        logic [3:0] d; logic e; int nl, ns, nc, ncl; bit to; exp_t x;
        req = 4'b0010;
        sb.push_back({4'b0010, 1'b1});
        tick();
        n_cmp++; if (grant !== 4'b0010) begin n_mis++; $display("FAIL st_grant: got %b expected 0010", grant); end
        req = '0;
        service(0, 0, d, e, nl, ns, nc, ncl, to);
        n_cmp++; if (to) begin n_mis++; $display("FAIL st_timeout: no done within budget"); end
        n_cmp++; if (nl != 16) begin n_mis++; $display("FAIL st_settle_len: got %0d expected 16", nl); end
        n_cmp++; if (ns != 0) begin n_mis++; $display("FAIL st_no_adc_start: got %0d pulses expected 0", ns); end
        x = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++; if ({d, e} !== x) begin n_mis++; $display("FAIL st_done: got done=%b err=%b expected done=%b err=%b", d, e, x.ch, x.e); end
        tick();
    endtask

    task automatic test_conv_timeout();
        logic [3:0] d; logic e; int nl, ns, nc, ncl; bit to; exp_t x;
        req = 4'b1000;
        sb.push_back({4'b1000, 1'b1});
        tick();
        n_cmp++; if (grant !== 4'b1000) begin n_mis++; $display("FAIL ct_grant: got %b expected 1000", grant); end
        req = '0;
        service(3, 0, d, e, nl, ns, nc, ncl, to);
        n_cmp++; if (to) begin n_mis++; $display("FAIL ct_timeout: no done within budget"); end
        n_cmp++; if (nc != 255) begin n_mis++; $display("FAIL ct_convert_len: got %0d expected 255", nc); end
        n_cmp++; if (ncl != 0) begin n_mis++; $display("FAIL ct_dly_clr_convert: got %0d low cycles expected 0", ncl); end
        x = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++; if ({d, e} !== x) begin n_mis++; $display("FAIL ct_done: got done=%b err=%b expected done=%b err=%b", d, e, x.ch, x.e); end
        tick();
    endtask

    task automatic test_drop_req();
        logic [3:0] d; logic e; int nl, ns, nc, ncl; bit to; exp_t x; bit bad;
        req = 4'b0001;
        sb.push_back({4'b0001, 1'b0});
        tick();
        n_cmp++; if (grant !== 4'b0001) begin n_mis++; $display("FAIL drop_grant: got %b expected 0001", grant); end
        req = '0;
        service(4, 2, d, e, nl, ns, nc, ncl, to);
        n_cmp++; if (to) begin n_mis++; $display("FAIL drop_timeout: no done within budget"); end
        x = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++; if ({d, e} !== x) begin n_mis++; $display("FAIL drop_done: got done=%b err=%b expected done=%b err=%b", d, e, x.ch, x.e); end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dly_done = i[0];
            adc_done = ~i[0];
            tick();
            if ({busy, grant, adc_start, done, err} !== 11'b0) bad = 1'b1;
        end
        dly_done = 1'b0;
        adc_done = 1'b0;
        n_cmp++; if (bad) begin n_mis++; $display("FAIL drop_stays_idle: got activity with no request expected none"); end
    endtask

    task automatic test_async_reset();
        logic [3:0] d; logic e; int nl, ns, nc, ncl; bit to; exp_t x;
        req = 4'b0100;
        tick();
        n_cmp++; if (grant !== 4'b0100) begin n_mis++; $display("FAIL ar_grant: got %b expected 0100", grant); end
        req = '0;
        dly_done = 1'b1;
        tick();
        dly_done = 1'b0;
        n_cmp++; if (adc_start !== 1'b1) begin n_mis++; $display("FAIL ar_in_convert: got adc_start=%b expected 1", adc_start); end
        tick();
        #3 rst = 1'b0;
        #1;
        n_cmp++; if ({dly_clr, grant, sel, adc_start, done, err, busy} !== RST_VALS) begin n_mis++; $display("FAIL ar_async_values: got %b expected %b", {dly_clr, grant, sel, adc_start, done, err, busy}, RST_VALS); end
        req = 4'b1001;
        sb.push_back({4'b0001, 1'b0});
        tick();
        n_cmp++; if ({busy, grant, done} !== 9'b0) begin n_mis++; $display("FAIL ar_held_in_reset: got busy=%b grant=%b done=%b expected all 0", busy, grant, done); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({grant, sel} !== 6'b0001_00) begin n_mis++; $display("FAIL ar_first_grant: got grant=%b sel=%0d expected 0001 0", grant, sel); end
        req = '0;
        service(1, 1, d, e, nl, ns, nc, ncl, to);
        n_cmp++; if (to) begin n_mis++; $display("FAIL ar_timeout: no done within budget"); end
        x = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++; if ({d, e} !== x) begin n_mis++; $display("FAIL ar_done: got done=%b err=%b expected done=%b err=%b", d, e, x.ch, x.e); end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_settle_timeout();
        test_conv_timeout();
        test_drop_req();
        test_async_reset();
        n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL scoreboard_drained: got %0d entries left expected 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got no finish expected finish before 500000");
        $fatal(1);
    end

endmodule
